adc_frame_ctrl: RTL and testbench

Capture sequencer between the ADC front end and the FFT input of the spectrometer. It converts offset-binary ADC samples to two's complement by inverting the MSB. It selects channel A, channel B, or alternating A/B per frame, and emits fixed-length frames on a valid/ready stream. An arm/trigger state machine, a frame counter and overflow detection control the capture.

---
 rtl/adc_frame_if.sv | 26 ++
 rtl/adc_frame_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_adc_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_if.sv
// Sample stream interface from the ADC capture sequencer to the FFT input.
interface adc_frame_if #(
    parameter int unsigned DATAWIDTH = 14
);
    logic [DATAWIDTH-1:0] m_tdata_o;
    logic                 m_tvalid_o;
    logic                 m_tready_i;
    logic                 m_tlast_o;
    logic                 m_tuser_o;

    modport master (
        output m_tdata_o,
        output m_tvalid_o,
        output m_tlast_o,
        output m_tuser_o,
        input  m_tready_i
    );

    modport slave (
        input  m_tdata_o,
        input  m_tvalid_o,
        input  m_tlast_o,
        input  m_tuser_o,
        output m_tready_i
    );
endinterface

// File: rtl/adc_frame_ctrl.sv
// ADC capture sequencer: offset-binary to two's complement, channel select, fixed-length frames.
// Optional macro ADC_FRAME_TRIG_EN adds the WAIT_TRIG state; otherwise arm starts streaming directly.
module adc_frame_ctrl #(
    parameter int unsigned DATAWIDTH    = 14,
    parameter int unsigned FFT_LEN_LOG2 = 10
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic [DATAWIDTH-1:0] adc_a_i,
    input  logic [DATAWIDTH-1:0] adc_b_i,
    input  logic [1:0]           ch_sel_i,
    input  logic [7:0]           frames_i,
    input  logic                 arm_i,
    input  logic                 trig_i,
    input  logic                 abort_i,
    adc_frame_if.master          m_axis,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 done_o
);
    localparam int unsigned IDX_W = FFT_LEN_LOG2;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_STREAM    = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [DATAWIDTH-1:0] r_tdata,    w_tdata_nxt;
    logic                 r_tvalid,   w_tvalid_nxt;
    logic                 r_tlast,    w_tlast_nxt;
    logic                 r_tuser,    w_tuser_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_overflow, w_overflow_nxt;
    logic                 r_done,     w_done_nxt;
    logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
    logic [CNT_W-1:0]     r_frame_cnt, w_frame_cnt_nxt;
    logic [CNT_W-1:0]     r_frames,   w_frames_nxt;
    logic                 r_alt,      w_alt_nxt;
    logic                 r_ch,       w_ch_nxt;

    logic [DATAWIDTH-1:0] w_conv_a;
    logic [DATAWIDTH-1:0] w_conv_b;
    logic                 w_writable;
    logic [CNT_W-1:0]     w_frame_inc;
    logic                 w_start;

    assign w_conv_a    = {~adc_a_i[DATAWIDTH-1], adc_a_i[DATAWIDTH-2:0]};
    assign w_conv_b    = {~adc_b_i[DATAWIDTH-1], adc_b_i[DATAWIDTH-2:0]};
    assign w_writable  = !r_tvalid || m_axis.m_tready_i;
    assign w_frame_inc = r_frame_cnt + CNT_W'(1);

`ifdef ADC_FRAME_TRIG_EN
    assign w_start = trig_i;
`else
    logic w_unused_trig;
    assign w_unused_trig = trig_i;
    assign w_start       = 1'b1;
`endif

    // Next-state and next-output logic; abort overrides everything at the end.
    always_comb begin
        w_state_nxt     = r_state;
        w_tdata_nxt     = r_tdata;
        w_tvalid_nxt    = r_tvalid;
        w_tlast_nxt     = r_tlast;
        w_tuser_nxt     = r_tuser;
        w_overflow_nxt  = r_overflow;
        w_done_nxt      = 1'b0;
        w_idx_nxt       = r_idx;
        w_frame_cnt_nxt = r_frame_cnt;
        w_frames_nxt    = r_frames;
        w_alt_nxt       = r_alt;
        w_ch_nxt        = r_ch;

        case (r_state)
            S_IDLE: begin
                if (arm_i) begin
                    w_frames_nxt    = frames_i;
                    w_alt_nxt       = (ch_sel_i == 2'b10);
                    w_ch_nxt        = (ch_sel_i == 2'b01);
                    w_overflow_nxt  = 1'b0;
                    w_idx_nxt       = '0;
                    w_frame_cnt_nxt = '0;
`ifdef ADC_FRAME_TRIG_EN
                    w_state_nxt     = S_WAIT_TRIG;
`else
                    w_state_nxt     = S_STREAM;
`endif
                end
            end
            S_WAIT_TRIG: begin
                if (w_start) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!w_writable) begin
                    // Downstream stalled while samples keep arriving: capture is lost.
                    w_overflow_nxt = 1'b1;
                    w_tvalid_nxt   = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_tdata_nxt  = r_ch ? w_conv_b : w_conv_a;
                    w_tuser_nxt  = r_ch;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (r_idx == IDX_LAST);
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_frame_cnt_nxt = w_frame_inc;
                        if (r_alt) begin
                            w_ch_nxt = ~r_ch;
                        end
                        if ((r_frames != '0) && (w_frame_inc == r_frames)) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (w_writable) begin
                    w_tvalid_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort_i) begin
            w_state_nxt    = S_IDLE;
            w_tvalid_nxt   = 1'b0;
            w_done_nxt     = 1'b0;
            w_overflow_nxt = r_overflow;
        end
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_state     <= S_IDLE;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_frames    <= '0;
            r_alt       <= 1'b0;
            r_ch        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tlast     <= w_tlast_nxt;
            r_tuser     <= w_tuser_nxt;
            r_busy      <= w_busy_nxt;
            r_overflow  <= w_overflow_nxt;
            r_done      <= w_done_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_frames    <= w_frames_nxt;
            r_alt       <= w_alt_nxt;
            r_ch        <= w_ch_nxt;
        end
    end

    assign m_axis.m_tdata_o  = r_tdata;
    assign m_axis.m_tvalid_o = r_tvalid;
    assign m_axis.m_tlast_o  = r_tlast;
    assign m_axis.m_tuser_o  = r_tuser;
    assign busy_o            = r_busy;
    assign overflow_o        = r_overflow;
    assign done_o            = r_done;
endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Self-checking bench for adc_frame_ctrl with a frame-level reference model (16-sample frames).
module tb_adc_frame_ctrl;
    localparam int unsigned DW   = 14;
    localparam int unsigned LOG2 = 4;
    localparam int          N    = 1 << LOG2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] adc_a = '0;
    logic [DW-1:0] adc_b = '0;
    logic [1:0]    ch_sel = '0;
    logic [7:0]    frames = '0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          overflow;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    adc_frame_if #(.DATAWIDTH(DW)) m_axis ();

    adc_frame_ctrl #(
        .DATAWIDTH    (DW),
        .FFT_LEN_LOG2 (LOG2)
    ) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rst_n),
        .adc_a_i    (adc_a),
        .adc_b_i    (adc_b),
        .ch_sel_i   (ch_sel),
        .frames_i   (frames),
        .arm_i      (arm),
        .trig_i     (trig),
        .abort_i    (abort),
        .m_axis     (m_axis),
        .busy_o     (busy),
        .overflow_o (overflow),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Offset binary to two's complement: shift by half scale, modulo full scale.
    function automatic logic [DW-1:0] to_tc(input logic [DW-1:0] x);
        int unsigned v;
        v = (int'(x) + (1 << (DW - 1))) % (1 << DW);
        return DW'(v);
    endfunction

    function automatic int chan_of(input int sel, input int frame);
        if (sel == 1) return 1;
        if (sel == 2) return frame % 2;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic arm_start(input int sel, input int nfr);
        ch_sel = 2'(sel);
        frames = 8'(nfr);
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
        chk("arm_busy", 32'(busy), 1);
        chk("arm_valid", 32'(m_axis.m_tvalid_o), 0);
        chk("arm_ovf_clr", 32'(overflow), 0);
        // Scramble configuration inputs: the capture must use the latched values.
        ch_sel = 2'($urandom);
        frames = 8'($urandom);
`ifdef ADC_FRAME_TRIG_EN
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("trig_valid", 32'(m_axis.m_tvalid_o), 0);
`endif
    endtask

    // pat: 0 random, 1 ramp on A from mid-scale, 2 A full-scale / B zero.
    task automatic stream(input int sel, input int nfr, input int pat,
                          input int abort_beat, input int drop_beat);
        int            total;
        int            stop;
        int            ch;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        total = (nfr == 0) ? 32'h4000_0000 : nfr * N;
        stop  = total;
        if (abort_beat >= 0 && abort_beat < stop) stop = abort_beat;
        if (drop_beat >= 0 && drop_beat < stop) stop = drop_beat;
        for (int i = 0; i <= stop; i++) begin
            case (pat)
                1:       begin a = DW'(32'h2000 + i); b = DW'($urandom); end
                2:       begin a = DW'(32'h3FFF);     b = '0;            end
                default: begin a = DW'($urandom);     b = DW'($urandom); end
            endcase
            adc_a = a;
            adc_b = b;
            abort = (i == abort_beat);
            m_axis.m_tready_i = (i != drop_beat);
            arm   = (i < stop) ? 1'($urandom) : 1'b0;
            trig  = 1'($urandom);
            tick();
            abort = 1'b0;
            arm   = 1'b0;
            trig  = 1'b0;
            m_axis.m_tready_i = 1'b1;
            if (i < stop) begin
                ch = chan_of(sel, i / N);
                chk("beat_valid", 32'(m_axis.m_tvalid_o), 1);
                chk("beat_data", 32'(m_axis.m_tdata_o), 32'(to_tc(ch != 0 ? b : a)));
                chk("beat_last", 32'(m_axis.m_tlast_o), ((i % N) == N - 1) ? 1 : 0);
                chk("beat_user", 32'(m_axis.m_tuser_o), 32'(ch));
                chk("beat_done", 32'(done), 0);
                chk("beat_busy", 32'(busy), 1);
                chk("beat_ovf", 32'(overflow), 0);
            end else if (stop == total) begin
                chk("end_valid", 32'(m_axis.m_tvalid_o), 0);
                chk("end_done", 32'(done), 1);
                chk("end_busy", 32'(busy), 0);
            end else begin
                chk("stop_valid", 32'(m_axis.m_tvalid_o), 0);
                chk("stop_done", 32'(done), 0);
                chk("stop_busy", 32'(busy), 0);
                chk("stop_ovf", 32'(overflow), (stop == drop_beat && stop != abort_beat) ? 1 : 0);
            end
        end
        tick();
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_valid", 32'(m_axis.m_tvalid_o), 0);
    endtask

    initial begin
        int sel;
        int nfr;
        int ab;
        m_axis.m_tready_i = 1'b1;
        repeat (3) tick();
        chk("rst_data", 32'(m_axis.m_tdata_o), 0);
        chk("rst_valid", 32'(m_axis.m_tvalid_o), 0);
        chk("rst_last", 32'(m_axis.m_tlast_o), 0);
        chk("rst_user", 32'(m_axis.m_tuser_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ramp on channel A, two frames.
        arm_start(0, 2);
        stream(0, 2, 1, -1, -1);

        // Alternating channels, four frames.
        arm_start(2, 4);
        stream(2, 4, 2, -1, -1);

        // One-cycle ready drop mid-frame, then a re-arm clears the flag.
        arm_start(0, 3);
        stream(0, 3, 0, -1, 21);
        chk("ovf_sticky", 32'(overflow), 1);
        arm_start(1, 1);
        stream(1, 1, 0, -1, -1);

        // Continuous capture aborted at sample 7 of the fifth frame.
        arm_start(2, 0);
        stream(2, 0, 0, 4 * N + 7, -1);

        // Randomised captures with occasional aborts.
        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(0, 3));
            nfr = int'($urandom_range(1, 3));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nfr * N - 1)) : -1;
            arm_start(sel, nfr);
            stream(sel, nfr, 0, ab, -1);
        end

        // Asynchronous reset in the middle of a frame.
        arm_start(1, 0);
        repeat (5) begin
            adc_b = DW'($urandom);
            tick();
        end
        chk("pre_rst_valid", 32'(m_axis.m_tvalid_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(m_axis.m_tdata_o), 0);
        chk("arst_valid", 32'(m_axis.m_tvalid_o), 0);
        chk("arst_last", 32'(m_axis.m_tlast_o), 0);
        chk("arst_user", 32'(m_axis.m_tuser_o), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        arm = 1'b1;
        trig = 1'b0;
        tick();
        arm = 1'b0;
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_valid0", 32'(m_axis.m_tvalid_o), 0);
`ifdef ADC_FRAME_TRIG_EN
        repeat (3) begin
            tick();
            chk("notrig_busy", 32'(busy), 1);
            chk("notrig_valid", 32'(m_axis.m_tvalid_o), 0);
        end
`else
        tick();
        chk("direct_valid", 32'(m_axis.m_tvalid_o), 1);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("final_abort_busy", 32'(busy), 0);
        chk("final_abort_valid", 32'(m_axis.m_tvalid_o), 0);
        chk("final_abort_done", 32'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
